// File: rtl/la_rng_pkg.sv
// Shared constants for the laRNG Wishbone reader: register offsets,
// STATUS/CTRL bit positions and the Wishbone handshake state type.
package la_rng_pkg;

    // Register offsets relative to BASE_ADDR
    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;

    // Byte span of the decoded register window (0x0..0xB)
    localparam logic [31:0] REG_SPAN = 32'd12;

    // STATUS fields
    localparam int ST_CNT_W    = 5;
    localparam int ST_OVF_BIT  = 8;
    localparam int ST_UNF_BIT  = 9;

    // CTRL fields
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_IE_BIT    = 1;
    localparam int CTRL_FLUSH_BIT = 2;

    // Wishbone slave handshake states
    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/la_rng_fifo.sv
// Synchronous word FIFO with flush. A push while full is accepted only when
// a pop happens in the same cycle; a pop while empty is ignored.
module la_rng_fifo
    import la_rng_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [WIDTH-1:0]    wdata_i,
    output logic [WIDTH-1:0]    rdata_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [ST_CNT_W-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [AW-1:0]       wptr_q, wptr_d;
    logic [AW-1:0]       rptr_q, rptr_d;
    logic [ST_CNT_W-1:0] count_q, count_d;
    logic                do_push, do_pop;

    assign full_o  = (count_q == ST_CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next pointer/count; flush overrides any push or pop in the same cycle
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer, count and storage registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/la_rng_reader.sv
// Packs the serial entropy stream into 32-bit words (first bit at bit31),
// buffers them in a small FIFO and exposes DATA/STATUS/CTRL over Wishbone.
module la_rng_reader
    import la_rng_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        resetb,
    input  logic        ent_bit,
    input  logic        ent_valid,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);

    wb_state_e           state_q, state_d;
    logic [31:0]         dat_q, dat_d;
    logic                en_q, en_d;
    logic                ie_q, ie_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [31:0]         word_q, word_d;
    logic [4:0]          bcnt_q, bcnt_d;
    logic                irq_q;

    logic                fifo_push, fifo_pop, fifo_flush;
    logic [31:0]         fifo_rdata;
    logic                fifo_full, fifo_empty;
    logic [ST_CNT_W-1:0] fifo_count;

    logic [31:0]         off;
    logic                hit, req;
    logic [3:0]          reg_sel;
    logic [31:0]         status_word, ctrl_word;

    // Byte select lanes and unused write-data bits carry no meaning here
    logic                unused_bits;
    assign unused_bits = ^{wbs_sel_i, wbs_dat_i};

    assign off     = wbs_adr_i - BASE_ADDR;
    assign hit     = (off < REG_SPAN);
    assign reg_sel = {off[3:2], 2'b00};
    assign req     = (state_q == WB_IDLE) && wbs_cyc_i && wbs_stb_i && hit;

    assign wbs_ack_o = (state_q == WB_ACK);
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;

    la_rng_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (resetb),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (word_d),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Readback images of STATUS and CTRL (FLUSH always reads 0)
    always_comb begin
        status_word                   = '0;
        status_word[ST_CNT_W-1:0]     = fifo_count;
        status_word[ST_OVF_BIT]       = ovf_q;
        status_word[ST_UNF_BIT]       = unf_q;
        ctrl_word                     = '0;
        ctrl_word[CTRL_EN_BIT]        = en_q;
        ctrl_word[CTRL_IE_BIT]        = ie_q;
    end

    // Assembler, register side-effects and Wishbone next-state
    always_comb begin
        state_d    = state_q;
        dat_d      = dat_q;
        en_d       = en_q;
        ie_d       = ie_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        word_d     = word_q;
        bcnt_d     = bcnt_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        // The push carries word_d, i.e. the completed word including this bit
        if (en_q && ent_valid) begin
            word_d = {word_q[30:0], ent_bit};
            bcnt_d = bcnt_q + 1'b1;
            if (bcnt_q == 5'd31) fifo_push = 1'b1;
        end

        case (state_q)
            WB_IDLE: if (req) state_d = WB_ACK;
            WB_ACK:  state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase

        if (req) begin
            case (reg_sel)
                OFF_DATA: begin
                    if (!wbs_we_i) begin
                        if (fifo_empty) begin
                            dat_d = '0;
                            unf_d = 1'b1;
                        end else begin
                            dat_d    = fifo_rdata;
                            fifo_pop = 1'b1;
                        end
                    end
                end
                OFF_STATUS: begin
                    if (wbs_we_i) begin
                        if (wbs_dat_i[ST_OVF_BIT]) ovf_d = 1'b0;
                        if (wbs_dat_i[ST_UNF_BIT]) unf_d = 1'b0;
                    end else begin
                        dat_d = status_word;
                    end
                end
                OFF_CTRL: begin
                    if (wbs_we_i) begin
                        en_d = wbs_dat_i[CTRL_EN_BIT];
                        ie_d = wbs_dat_i[CTRL_IE_BIT];
                        if (wbs_dat_i[CTRL_FLUSH_BIT]) begin
                            fifo_flush = 1'b1;
                            word_d     = '0;
                            bcnt_d     = '0;
                        end
                    end else begin
                        dat_d = ctrl_word;
                    end
                end
                default: ;
            endcase
        end

        // A word lost to a full FIFO wins over a same-cycle W1C of OVF
        if (fifo_push && fifo_full && !fifo_pop && !fifo_flush) ovf_d = 1'b1;
    end

    // Control and datapath registers
    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            state_q <= WB_IDLE;
            dat_q   <= '0;
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            word_q  <= '0;
            bcnt_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            en_q    <= en_d;
            ie_q    <= ie_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            word_q  <= word_d;
            bcnt_q  <= bcnt_d;
            irq_q   <= ie_q && !fifo_empty;
        end
    end

endmodule

// File: tb/tb_la_rng_reader.sv
// Bench for la_rng_reader: scenario tasks with a word scoreboard.
module tb_la_rng_reader;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_DATA   = BASE + 32'h0;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_CTRL   = BASE + 32'h8;

    logic        wb_clk_i = 1'b0;
    logic        resetb   = 1'b0;
    logic        ent_bit  = 1'b0;
    logic        ent_valid = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i  = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        irq_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb_q[$];

    la_rng_reader #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .resetb    (resetb),
        .ent_bit   (ent_bit),
        .ent_valid (ent_valid),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .irq_o     (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wb_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = addr;
        lat = 0;
        data = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            lat++;
            if (wbs_ack_o) break;
        end
        if (!wbs_ack_o) begin
            total++; bad++;
            $display("FAIL rd_timeout addr=%h got no ack after %0d cycles, need ack", addr, lat);
        end
        data = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tick();
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_adr_i = addr; wbs_dat_i = data;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wbs_ack_o) break;
        end
        if (!wbs_ack_o) begin
            total++; bad++;
            $display("FAIL wr_timeout addr=%h got no ack, need ack", addr);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        tick();
    endtask

    // Shift out the top n bits of w, MSB first, one valid bit per cycle
    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            ent_valid = 1'b1;
            ent_bit   = w[31-i];
            tick();
        end
        ent_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit expect_kept);
        send_bits(w, 32);
        if (expect_kept) sb_q.push_back(w);
    endtask

    task automatic check_data_read(input string name);
        logic [31:0] d, exp;
        int lat;
        wb_read(A_DATA, d, lat);
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard empty, got %h", name, d);
        end else begin
            exp = sb_q.pop_front();
            if (d !== exp) begin
                bad++;
                $display("FAIL %s data got %h need %h", name, d, exp);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int lat;
        total++;
        if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0 || irq_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got ack=%b dat=%h irq=%b need 0/0/0", wbs_ack_o, wbs_dat_o, irq_o);
        end
        wb_read(A_STATUS, d, lat);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_status got %h need 0", d); end
        wb_read(A_CTRL, d, lat);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl got %h need 0", d); end
        // EN=0: entropy must be ignored
        send_bits(32'hFFFF_FFFF, 32);
        wb_read(A_STATUS, d, lat);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL en_off_status got %h need 0", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d, exp;
        int lat;
        wb_write(A_CTRL, 32'h1);
        send_word(32'hAAAA_AAAA, 1'b1);
        wb_read(A_STATUS, d, lat);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL basic_status1 got %h need 1", d); end
        wb_read(A_DATA, d, lat);
        exp = sb_q.pop_front();
        total++;
        if (d !== exp) begin bad++; $display("FAIL basic_data got %h need %h", d, exp); end
        total++;
        if (lat !== 1) begin bad++; $display("FAIL basic_latency got %0d need 1", lat); end
        wb_read(A_STATUS, d, lat);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL basic_status0 got %h need 0", d); end
        // irq follows non-empty when IE=1
        wb_write(A_CTRL, 32'h3);
        send_word(32'h0F0F_1234, 1'b1);
        tick();
        total++;
        if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_set got %b need 1", irq_o); end
        check_data_read("irq_data");
        tick();
        total++;
        if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_clear got %b need 0", irq_o); end
        wb_write(A_CTRL, 32'h1);
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        int lat;
        for (int i = 1; i <= 4; i++) send_word(32'(i), 1'b1);
        send_word(32'h5, 1'b0);
        wb_read(A_STATUS, d, lat);
        total++;
        if (d !== 32'h104) begin bad++; $display("FAIL ovf_status got %h need 104", d); end
        for (int i = 0; i < 4; i++) check_data_read("ovf_order");
        wb_write(A_STATUS, 32'h100);
        wb_read(A_STATUS, d, lat);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL ovf_w1c got %h need 0", d); end
    endtask

    task automatic test_underflow();
        logic [31:0] d;
        int lat;
        wb_read(A_DATA, d, lat);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL unf_data got %h need 0", d); end
        wb_read(A_STATUS, d, lat);
        total++;
        if (d !== 32'h200) begin bad++; $display("FAIL unf_status got %h need 200", d); end
        wb_write(A_STATUS, 32'h200);
        wb_read(A_STATUS, d, lat);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL unf_w1c got %h need 0", d); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] d, exp, w5;
        int lat;
        w5 = 32'hC0DE_0005;
        for (int i = 0; i < 4; i++) send_word(32'hA0 + 32'(i), 1'b1);
        send_bits(w5, 31);
        // 32nd bit and DATA pop sampled on the same edge
        ent_valid = 1'b1; ent_bit = w5[0];
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_DATA;
        sb_q.push_back(w5);
        tick();
        ent_valid = 1'b0;
        total++;
        if (wbs_ack_o !== 1'b1) begin bad++; $display("FAIL pp_ack got %b need 1", wbs_ack_o); end
        exp = sb_q.pop_front();
        total++;
        if (wbs_dat_o !== exp) begin bad++; $display("FAIL pp_data got %h need %h", wbs_dat_o, exp); end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tick();
        wb_read(A_STATUS, d, lat);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL pp_status got %h need 4", d); end
        for (int i = 0; i < 4; i++) check_data_read("pp_order");
    endtask

    task automatic test_flush();
        logic [31:0] d;
        int lat;
        send_word(32'h5555_0001, 1'b1);
        send_bits(32'hFFFF_F000, 20);
        wb_write(A_CTRL, 32'h5);
        sb_q.delete();
        wb_read(A_STATUS, d, lat);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL flush_status got %h need 0", d); end
        wb_read(A_CTRL, d, lat);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL flush_ctrl got %h need 1", d); end
        send_word(32'h1234_5678, 1'b1);
        check_data_read("flush_clean_word");
    endtask

    task automatic test_decode();
        logic seen;
        seen = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE + 32'hC;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wbs_ack_o) seen = 1'b1;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tick();
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL decode_oob got ack=1 need no ack"); end
    endtask

    task automatic test_reset_midtransfer();
        logic [31:0] d;
        logic seen;
        int lat;
        wb_write(A_CTRL, 32'h3);
        send_word(32'h1111_0001, 1'b1);
        send_word(32'h2222_0002, 1'b1);
        tick();
        total++;
        if (irq_o !== 1'b1) begin bad++; $display("FAIL rst_pre_irq got %b need 1", irq_o); end
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_DATA;
        #3;
        resetb = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wbs_ack_o) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL rst_ack got ack=1 need 0"); end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        resetb = 1'b1;
        sb_q.delete();
        tick();
        total++;
        if (irq_o !== 1'b0) begin bad++; $display("FAIL rst_irq got %b need 0", irq_o); end
        wb_read(A_STATUS, d, lat);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL rst_status got %h need 0", d); end
        wb_read(A_CTRL, d, lat);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL rst_ctrl got %h need 0", d); end
    endtask

    initial begin
        repeat (3) @(posedge wb_clk_i);
        #1;
        resetb = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_overflow();
        test_underflow();
        test_push_pop_full();
        test_flush();
        test_decode();
        test_reset_midtransfer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
